// File: rtl/fsm_req_burst.sv
// fsm_req_burst: request-side stage in front of the 4-agent grant arbiter.
// Each agent owns an independent FSM that accepts a burst command, raises
// req_N until the granted beats cover the whole burst, then waits for the
// grant to clear before signalling completion.
// Optional feature macro: REQ_TIMEOUT_EN (abort a request that waits more
// than TIMEOUT cycles in REQ without a grant).
module fsm_req_burst #(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [3:0]         cmd_valid,
    input  logic [4*LEN_W-1:0] cmd_len,
    output logic [3:0]         cmd_ready,
    input  logic [3:0]         beat_stall,
    input  logic               gnt_0,
    input  logic               gnt_1,
    input  logic               gnt_2,
    input  logic               gnt_3,
    output logic               req_0,
    output logic               req_1,
    output logic               req_2,
    output logic               req_3,
    output logic [3:0]         beat,
    output logic [3:0]         done,
    output logic [3:0]         timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_XFER    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // TIMEOUT is an 8-bit compare target; anything outside 2..255 is a
    // configuration error caught at elaboration.
    if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_timeout_range_bad
        $error("fsm_req_burst: TIMEOUT must be within 2..255");
    end

    state_t           state_r [4];
    logic [LEN_W-1:0] rem_r   [4];
    logic [3:0]       req_r;
    logic [3:0]       done_r;
    logic [3:0]       timeout_r;
    logic [3:0]       abort_r;
    logic [3:0]       gnt_s;
`ifdef REQ_TIMEOUT_EN
    logic [7:0]       wait_r  [4];
`endif

    assign gnt_s   = {gnt_3, gnt_2, gnt_1, gnt_0};
    assign req_0   = req_r[0];
    assign req_1   = req_r[1];
    assign req_2   = req_r[2];
    assign req_3   = req_r[3];
    assign done    = done_r;
    assign timeout = timeout_r;

    // Command handshake and grant-gated beat strobes, decoded from registered state.
    always_comb begin
        cmd_ready = 4'b0000;
        beat      = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if ((state_r[i] == ST_IDLE) && !reset) begin
                cmd_ready[i] = 1'b1;
            end else begin
                cmd_ready[i] = 1'b0;
            end
            if ((state_r[i] == ST_XFER) && gnt_s[i] && !beat_stall[i]) begin
                beat[i] = 1'b1;
            end else begin
                beat[i] = 1'b0;
            end
        end
    end

    // Per-agent burst FSMs with registered req/done/timeout outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                state_r[i] <= ST_IDLE;
                rem_r[i]   <= {LEN_W{1'b0}};
`ifdef REQ_TIMEOUT_EN
                wait_r[i]  <= 8'd0;
`endif
            end
            req_r     <= 4'b0000;
            done_r    <= 4'b0000;
            timeout_r <= 4'b0000;
            abort_r   <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                // Pulses default low; set for one cycle below when they fire.
                done_r[i]    <= 1'b0;
                timeout_r[i] <= 1'b0;
                case (state_r[i])
                    ST_IDLE: begin
                        if (cmd_valid[i] && cmd_ready[i]) begin
                            rem_r[i]   <= cmd_len[i*LEN_W +: LEN_W];
                            state_r[i] <= ST_REQ;
                            req_r[i]   <= 1'b1;
                            abort_r[i] <= 1'b0;
`ifdef REQ_TIMEOUT_EN
                            wait_r[i]  <= 8'd0;
`endif
                        end
                    end
                    ST_REQ: begin
                        // A grant wins over a timeout that expires in the same cycle.
                        if (gnt_s[i]) begin
                            state_r[i] <= ST_XFER;
                        end
`ifdef REQ_TIMEOUT_EN
                        else if (wait_r[i] == 8'(TIMEOUT - 1)) begin
                            state_r[i]   <= ST_RELEASE;
                            req_r[i]     <= 1'b0;
                            timeout_r[i] <= 1'b1;
                            abort_r[i]   <= 1'b1;
                        end else begin
                            wait_r[i] <= wait_r[i] + 8'd1;
                        end
`endif
                    end
                    ST_XFER: begin
                        if (!gnt_s[i]) begin
                            // Grant lost mid-burst: re-request, keep remaining count.
                            state_r[i] <= ST_REQ;
`ifdef REQ_TIMEOUT_EN
                            wait_r[i]  <= 8'd0;
`endif
                        end else if (!beat_stall[i]) begin
                            if (rem_r[i] == {LEN_W{1'b0}}) begin
                                state_r[i] <= ST_RELEASE;
                                req_r[i]   <= 1'b0;
                            end else begin
                                rem_r[i] <= rem_r[i] - {{(LEN_W-1){1'b0}}, 1'b1};
                            end
                        end
                    end
                    ST_RELEASE: begin
                        // Hold off until the arbiter's grant has actually cleared.
                        if (!gnt_s[i]) begin
                            state_r[i] <= ST_IDLE;
                            done_r[i]  <= !abort_r[i];
                            abort_r[i] <= 1'b0;
                        end
                    end
                    default: begin
                        state_r[i] <= ST_IDLE;
                        req_r[i]   <= 1'b0;
                        abort_r[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fsm_req_burst.sv
// Scoreboard bench for fsm_req_burst: directed stimulus pushes expected
// beat/done/timeout events (kind, agent, cycle); a negedge monitor pops one
// entry per observed strobe bit and compares.
module tb_fsm_req_burst;

    localparam int LEN_W = 4;
    localparam int TO    = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  cmd_valid;
    logic [15:0] cmd_len;
    logic [3:0]  cmd_ready;
    logic [3:0]  beat_stall;
    logic [3:0]  gnt;
    wire  [3:0]  req;
    logic [3:0]  beat;
    logic [3:0]  done;
    logic [3:0]  timeout;

    fsm_req_burst #(.LEN_W(LEN_W), .TIMEOUT(TO)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_len    (cmd_len),
        .cmd_ready  (cmd_ready),
        .beat_stall (beat_stall),
        .gnt_0      (gnt[0]),
        .gnt_1      (gnt[1]),
        .gnt_2      (gnt[2]),
        .gnt_3      (gnt[3]),
        .req_0      (req[0]),
        .req_1      (req[1]),
        .req_2      (req[2]),
        .req_3      (req[3]),
        .beat       (beat),
        .done       (done),
        .timeout    (timeout)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]  kind;   // 0 beat, 1 done, 2 timeout
        logic [1:0]  agent;
        logic [31:0] at;
    } ev_t;

    ev_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int agent, input int at);
        ev_t e;
        e.kind  = 2'(kind);
        e.agent = 2'(agent);
        e.at    = 32'(at);
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: each strobe bit seen consumes one scoreboard entry.
    always @(negedge clock) begin
        logic [3:0] v [3];
        ev_t e;
        v[0] = beat;
        v[1] = done;
        v[2] = timeout;
        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < 4; a++) begin
                if (v[k][a] !== 1'b0) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL sb_unexpected: got kind %0d agent %0d cycle %0d, required no event", k, a, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if ((32'(e.kind) != 32'(k)) || (32'(e.agent) != 32'(a)) || (e.at != 32'(cyc))) begin
                            failures++;
                            $display("FAIL sb_event: got kind %0d agent %0d cycle %0d, required kind %0d agent %0d cycle %0d",
                                     k, a, cyc, e.kind, e.agent, e.at);
                        end
                    end
                end
            end
        end
    end

    int c;

    initial begin
        reset      = 1'b1;
        cmd_valid  = 4'b0000;
        cmd_len    = 16'h0000;
        beat_stall = 4'b0000;
        gnt        = 4'b0000;
        step();
        step();
        reset = 1'b0;

        // Reset then idle
        repeat (5) step();
        check("idle_req", 32'(req), 32'h0);
        check("idle_cmd_ready", 32'(cmd_ready), 32'hF);
        check("idle_beat", 32'(beat), 32'h0);
        check("idle_done", 32'(done), 32'h0);
        check("idle_timeout", 32'(timeout), 32'h0);

        // Agent 1, len 3, grant two cycles after req; len changes after accept are ignored
        c = cyc;
        cmd_valid = 4'b0010;
        cmd_len   = 16'h0030;
        for (int i = 4; i <= 7; i++) expect_ev(0, 1, c + i);
        expect_ev(1, 1, c + 11);
        step();                         // c+1
        cmd_valid = 4'b0000;
        cmd_len   = 16'hFFFF;
        check("a1_req_rise", 32'(req), 32'h2);
        check("a1_ready_busy", 32'(cmd_ready), 32'hD);
        step(); step();                 // c+3
        gnt = 4'b0010;
        repeat (4) step();              // c+7
        check("a1_req_last_beat", 32'(req), 32'h2);
        step();                         // c+8
        check("a1_req_fall", 32'(req), 32'h0);
        step(); step();                 // c+10
        gnt = 4'b0000;
        step();                         // c+11
        check("a1_ready_back", 32'(cmd_ready), 32'hF);
        step();

        // Agent 0, len 2, two stall cycles mid-burst
        c = cyc;
        cmd_valid = 4'b0001;
        cmd_len   = 16'h0002;
        expect_ev(0, 0, c + 2);
        expect_ev(0, 0, c + 5);
        expect_ev(0, 0, c + 6);
        expect_ev(1, 0, c + 8);
        step();                         // c+1
        cmd_valid = 4'b0000;
        gnt = 4'b0001;
        step();                         // c+2
        step();                         // c+3
        beat_stall = 4'b0001;
        step();                         // c+4
        step();                         // c+5
        beat_stall = 4'b0000;
        step();                         // c+6
        step();                         // c+7
        gnt = 4'b0000;
        check("a0_req_fall", 32'(req), 32'h0);
        step();                         // c+8
        step();

        // All four agents, len 0, arbiter serves 0..3 with one cycle of grant-clear lag
        c = cyc;
        cmd_valid = 4'b1111;
        cmd_len   = 16'h0000;
        expect_ev(0, 0, c + 2);
        expect_ev(0, 1, c + 5);
        expect_ev(1, 0, c + 5);
        expect_ev(0, 2, c + 8);
        expect_ev(1, 1, c + 8);
        expect_ev(0, 3, c + 11);
        expect_ev(1, 2, c + 11);
        expect_ev(1, 3, c + 14);
        step();                         // c+1
        cmd_valid = 4'b0000;
        check("all_ready_busy", 32'(cmd_ready), 32'h0);
        for (int w = 1; w <= 15; w++) begin
            logic [3:0] g;
            logic [3:0] r;
            for (int k = 0; k < 4; k++) begin
                g[k] = (w >= 1 + 3*k) && (w <= 3 + 3*k);
                r[k] = (w <= 2 + 3*k);
            end
            gnt = g;
            check("all_req", 32'(req), 32'(r));
            if (w < 15) step();
        end
        step();
        check("all_ready_back", 32'(cmd_ready), 32'hF);

        // Reset while agent 2 is in XFER with rem=5: no done
        c = cyc;
        cmd_valid = 4'b0100;
        cmd_len   = 16'h0500;
        step();                         // c+1
        cmd_valid = 4'b0000;
        gnt = 4'b0100;
        step();                         // c+2 (XFER, stalled)
        beat_stall = 4'b0100;
        reset = 1'b1;
        step();                         // c+3
        reset = 1'b0;
        beat_stall = 4'b0000;
        #1;
        check("rst_req", 32'(req), 32'h0);
        check("rst_beat", 32'(beat), 32'h0);
        check("rst_ready", 32'(cmd_ready), 32'hF);
        step();
        gnt = 4'b0000;
        step(); step();

`ifdef REQ_TIMEOUT_EN
        // Agent 2 never granted: abort after TO REQ cycles, timeout pulse, no done
        c = cyc;
        cmd_valid = 4'b0100;
        cmd_len   = 16'h0300;
        expect_ev(2, 2, c + TO + 1);
        step();                         // c+1
        cmd_valid = 4'b0000;
        repeat (TO - 1) step();         // c+TO
        check("to_req_held", 32'(req), 32'h4);
        step();                         // c+TO+1
        check("to_req_fall", 32'(req), 32'h0);
        check("to_ready_release", 32'(cmd_ready), 32'hB);
        step();                         // c+TO+2
        check("to_ready_back", 32'(cmd_ready), 32'hF);
        step();
`else
        // Without the timeout feature REQ waits indefinitely
        c = cyc;
        cmd_valid = 4'b0100;
        cmd_len   = 16'h0000;
        step();                         // c+1
        cmd_valid = 4'b0000;
        repeat (30) step();             // c+31
        check("nto_req_held", 32'(req), 32'h4);
        check("nto_ready_busy", 32'(cmd_ready), 32'hB);
        gnt = 4'b0100;
        expect_ev(0, 2, c + 32);
        expect_ev(1, 2, c + 34);
        step();                         // c+32
        step();                         // c+33
        gnt = 4'b0000;
        check("nto_req_fall", 32'(req), 32'h0);
        step();                         // c+34
        step();
`endif

        step();
        check("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
